// File: rtl/amber128_pkg.sv
// Shared constants and sweep-state encoding for the amber128 capability register file.
package amber128_pkg;

  localparam int C_XLEN        = 128;
  localparam int CAP_REG_COUNT = 32;
  localparam int CAP_REG_AW    = $clog2(CAP_REG_COUNT);
  localparam int CAP_EPOCH_LSB = 112;
  localparam int CAP_EPOCH_W   = 8;

  typedef enum logic [1:0] {
    SWP_IDLE = 2'd0,
    SWP_RUN  = 2'd1,
    SWP_DONE = 2'd2
  } swp_state_e;

endpackage

// File: rtl/amber128_capfile_sweep.sv
// Revocation sweep engine: walks entries 1..REG_COUNT-1 and strobes a tag clear
// for each tagged entry whose epoch matches the latched one.
module amber128_capfile_sweep
  import amber128_pkg::*;
#(
  parameter int REG_COUNT = CAP_REG_COUNT,
  parameter int AW        = $clog2(REG_COUNT),
  parameter int EPOCH_W   = CAP_EPOCH_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic [EPOCH_W-1:0] epoch_i,
  input  logic               entry_tag_i,
  input  logic [EPOCH_W-1:0] entry_epoch_i,
  input  logic               wr_hit_i,
  output logic [AW-1:0]      idx_o,
  output logic               clr_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [AW:0]        cnt_o
);

  swp_state_e         r_state;
  swp_state_e         w_state_next;
  logic [AW-1:0]      r_idx;
  logic [EPOCH_W-1:0] r_epoch;
  logic [AW:0]        r_cnt;
  logic [AW:0]        r_cnt_out;
  logic [AW:0]        w_cnt_inc;
  logic               w_last;

  assign w_last    = (r_idx == AW'(REG_COUNT - 1));
  assign w_cnt_inc = r_cnt + (AW + 1)'(clr_o);

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    clr_o        = 1'b0;
    case (r_state)
      SWP_IDLE: begin
        ready_o = 1'b1;
        if (req_i) w_state_next = SWP_RUN;
      end
      SWP_RUN: begin
        busy_o = 1'b1;
        // A same-cycle architectural write to this entry takes precedence over revocation.
        clr_o  = entry_tag_i && (entry_epoch_i == r_epoch) && !wr_hit_i;
        if (w_last) w_state_next = SWP_DONE;
      end
      SWP_DONE: begin
        done_o       = 1'b1;
        w_state_next = SWP_IDLE;
      end
      default: w_state_next = SWP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= SWP_IDLE;
      r_idx     <= '0;
      r_epoch   <= '0;
      r_cnt     <= '0;
      r_cnt_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == SWP_IDLE && req_i) begin
        r_epoch <= epoch_i;
        r_idx   <= AW'(1);
        r_cnt   <= '0;
      end else if (r_state == SWP_RUN) begin
        r_idx <= r_idx + AW'(1);
        r_cnt <= w_cnt_inc;
        if (w_last) r_cnt_out <= w_cnt_inc;
      end
    end
  end

  assign idx_o = r_idx;
  assign cnt_o = r_cnt_out;

endmodule

// File: rtl/amber128_capfile_mp.sv
// Multi-port tagged capability register file with hardwired-null r0 and revocation sweep.
// Define AMBER128_CAPFILE_BYPASS_EN to forward same-cycle write data/tag to the read ports.
module amber128_capfile_mp
  import amber128_pkg::*;
#(
  parameter int NUM_RD    = 3,
  parameter int NUM_WR    = 2,
  parameter int REG_COUNT = CAP_REG_COUNT,
  parameter int AW        = $clog2(REG_COUNT),
  parameter int EPOCH_LSB = CAP_EPOCH_LSB,
  parameter int EPOCH_W   = CAP_EPOCH_W
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_WR-1:0]              we_i,
  input  logic [NUM_WR-1:0][AW-1:0]      waddr_i,
  input  logic [NUM_WR-1:0][C_XLEN-1:0]  wdata_i,
  input  logic [NUM_WR-1:0]              wtag_i,
  input  logic [NUM_RD-1:0][AW-1:0]      raddr_i,
  output logic [NUM_RD-1:0][C_XLEN-1:0]  rdata_o,
  output logic [NUM_RD-1:0]              rtag_o,
  input  logic                           sweep_req_i,
  input  logic [EPOCH_W-1:0]             sweep_epoch_i,
  output logic                           sweep_ready_o,
  output logic                           sweep_busy_o,
  output logic                           sweep_done_o,
  output logic [AW:0]                    sweep_cnt_o
);

  logic [C_XLEN-1:0] r_data [REG_COUNT];
  logic [REG_COUNT-1:0] r_tag;

  logic [AW-1:0]     w_swp_idx;
  logic              w_swp_clr;
  logic [NUM_WR-1:0] w_hit_vec;
  logic              w_wr_hit;

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_hit
    assign w_hit_vec[gi] = we_i[gi] && (waddr_i[gi] == w_swp_idx);
  end
  assign w_wr_hit = |w_hit_vec;

  amber128_capfile_sweep #(
    .REG_COUNT(REG_COUNT),
    .AW       (AW),
    .EPOCH_W  (EPOCH_W)
  ) u_sweep (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (sweep_req_i),
    .epoch_i      (sweep_epoch_i),
    .entry_tag_i  (r_tag[w_swp_idx]),
    .entry_epoch_i(r_data[w_swp_idx][EPOCH_LSB +: EPOCH_W]),
    .wr_hit_i     (w_wr_hit),
    .idx_o        (w_swp_idx),
    .clr_o        (w_swp_clr),
    .ready_o      (sweep_ready_o),
    .busy_o       (sweep_busy_o),
    .done_o       (sweep_done_o),
    .cnt_o        (sweep_cnt_o)
  );

  // Later port iterations override earlier ones, giving the highest index priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < REG_COUNT; e++) r_data[e] <= '0;
      r_tag <= '0;
    end else begin
      if (w_swp_clr) r_tag[w_swp_idx] <= 1'b0;
      for (int e = 1; e < REG_COUNT; e++) begin
        for (int wp = 0; wp < NUM_WR; wp++) begin
          if (we_i[wp] && (waddr_i[wp] == AW'(e))) begin
            r_data[e] <= wdata_i[wp];
            r_tag[e]  <= wtag_i[wp];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    rtag_o  = '0;
    for (int rp = 0; rp < NUM_RD; rp++) begin
      rdata_o[rp] = r_data[raddr_i[rp]];
      rtag_o[rp]  = r_tag[raddr_i[rp]];
`ifdef AMBER128_CAPFILE_BYPASS_EN
      for (int wp = 0; wp < NUM_WR; wp++) begin
        if (we_i[wp] && (waddr_i[wp] == raddr_i[rp])) begin
          rdata_o[rp] = wdata_i[wp];
          rtag_o[rp]  = wtag_i[wp];
        end
      end
`endif
      if (raddr_i[rp] == '0) begin
        rdata_o[rp] = '0;
        rtag_o[rp]  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amber128_capfile_mp.sv
// Directed self-checking bench for amber128_capfile_mp (3 read / 2 write ports, 32 entries).
module tb_amber128_capfile_mp;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        we_i;
  logic [1:0][4:0]   waddr_i;
  logic [1:0][127:0] wdata_i;
  logic [1:0]        wtag_i;
  logic [2:0][4:0]   raddr_i;
  logic [2:0][127:0] rdata_o;
  logic [2:0]        rtag_o;
  logic              sweep_req_i;
  logic [7:0]        sweep_epoch_i;
  logic              sweep_ready_o;
  logic              sweep_busy_o;
  logic              sweep_done_o;
  logic [5:0]        sweep_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  amber128_capfile_mp dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .wtag_i       (wtag_i),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
    .rtag_o       (rtag_o),
    .sweep_req_i  (sweep_req_i),
    .sweep_epoch_i(sweep_epoch_i),
    .sweep_ready_o(sweep_ready_o),
    .sweep_busy_o (sweep_busy_o),
    .sweep_done_o (sweep_done_o),
    .sweep_cnt_o  (sweep_cnt_o)
  );

  function automatic logic [127:0] mk(input logic [7:0] ep, input logic [31:0] lo);
    logic [127:0] d;
    d = '0;
    d[31:0] = lo;
    d[119:112] = ep;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    we_i = '0; sweep_req_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wr2(input logic [4:0] a0, input logic [127:0] d0, input logic t0,
                     input logic [4:0] a1, input logic [127:0] d1, input logic t1);
    we_i = 2'b11;
    waddr_i[0] = a0; wdata_i[0] = d0; wtag_i[0] = t0;
    waddr_i[1] = a1; wdata_i[1] = d1; wtag_i[1] = t1;
    tick();
    we_i = 2'b00;
  endtask

  task automatic rd_check(input string nm, input logic [4:0] a,
                          input logic [127:0] ed, input logic et);
    raddr_i[0] = a;
    #1;
    n_cmp++;
    if (rdata_o[0] !== ed || rtag_o[0] !== et) begin
      n_bad++;
      $display("FAIL %s: got data=%h tag=%b, want data=%h tag=%b", nm, rdata_o[0], rtag_o[0], ed, et);
    end else $display("ok   %s: data=%h tag=%b", nm, rdata_o[0], rtag_o[0]);
  endtask

  // Returns after the DONE cycle is observed (or the bound expires).
  task automatic run_sweep(input logic [7:0] ep, input int coll_at,
                           output int busy_n, output bit done_seen);
    sweep_req_i = 1'b1; sweep_epoch_i = ep;
    tick();
    sweep_req_i = 1'b0;
    busy_n = 0; done_seen = 0;
    for (int g = 0; g < 100; g++) begin
      if (sweep_done_o) begin done_seen = 1; break; end
      if (sweep_busy_o) busy_n++;
      if (g == coll_at) begin
        we_i = 2'b11;
        waddr_i[0] = 5'd9; wdata_i[0] = mk(8'h04, 32'h99); wtag_i[0] = 1'b1;
        waddr_i[1] = 5'd2; wdata_i[1] = mk(8'h04, 32'h22); wtag_i[1] = 1'b1;
      end else we_i = 2'b00;
      tick();
    end
    we_i = 2'b00;
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL sweep_timeout: got no done pulse, want done within 100 cycles");
    end else if (sweep_ready_o !== 1'b0 || sweep_busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_state: got ready=%b busy=%b, want ready=0 busy=0", sweep_ready_o, sweep_busy_o);
    end else $display("ok   sweep epoch=%h busy_cycles=%0d cnt=%0d", ep, busy_n, sweep_cnt_o);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end else $display("ok   %s: %0d", nm, got);
  endtask

  task automatic test_reset();
    wr2(5'd5, {4{32'hA5A5A5A5}}, 1'b1, 5'd5, {4{32'hA5A5A5A5}}, 1'b1);
    rd_check("pre_reset_r5", 5'd5, {4{32'hA5A5A5A5}}, 1'b1);
    do_reset();
    rd_check("reset_r5", 5'd5, 128'h0, 1'b0);
    chk_val("reset_ready", 32'(sweep_ready_o), 32'd1);
    chk_val("reset_busy", 32'(sweep_busy_o), 32'd0);
    chk_val("reset_cnt", 32'(sweep_cnt_o), 32'd0);
  endtask

  task automatic test_write_priority();
    wr2(5'd7, 128'h11, 1'b0, 5'd7, 128'h22, 1'b1);
    rd_check("prio_r7", 5'd7, 128'h22, 1'b1);
    raddr_i[2] = 5'd7;
    #1;
    chk_val("prio_r7_port2_lo", rdata_o[2][31:0], 32'h22);
    wr2(5'd0, 128'hFFFF, 1'b1, 5'd0, 128'hEEEE, 1'b1);
    rd_check("r0_null", 5'd0, 128'h0, 1'b0);
  endtask

  task automatic test_bypass();
    wr2(5'd3, 128'h1234, 1'b0, 5'd4, 128'h4444, 1'b1);
    we_i = 2'b01;
    waddr_i[0] = 5'd3; wdata_i[0] = 128'hBEEF; wtag_i[0] = 1'b1;
`ifdef AMBER128_CAPFILE_BYPASS_EN
    rd_check("bypass_same_cycle", 5'd3, 128'hBEEF, 1'b1);
`else
    rd_check("nobypass_same_cycle", 5'd3, 128'h1234, 1'b0);
`endif
    tick();
    we_i = 2'b00;
    rd_check("bypass_next_cycle", 5'd3, 128'hBEEF, 1'b1);
    we_i = 2'b10;
    waddr_i[1] = 5'd0; wdata_i[1] = 128'h5; wtag_i[1] = 1'b1;
    rd_check("bypass_r0", 5'd0, 128'h0, 1'b0);
    tick();
    we_i = 2'b00;
  endtask

  task automatic setup_epochs();
    wr2(5'd2, mk(8'h04, 32'h2), 1'b1, 5'd9, mk(8'h04, 32'h9), 1'b1);
    wr2(5'd31, mk(8'h04, 32'h31), 1'b1, 5'd10, mk(8'h05, 32'h10), 1'b1);
    wr2(5'd11, mk(8'h04, 32'h11), 1'b0, 5'd11, mk(8'h04, 32'h11), 1'b0);
  endtask

  task automatic test_sweep();
    int  bn;
    bit  ds;
    do_reset();
    setup_epochs();
    run_sweep(8'h04, -1, bn, ds);
    chk_val("sweep_busy_cycles", 32'(bn), 32'd31);
    chk_val("sweep_cnt", 32'(sweep_cnt_o), 32'd3);
    tick();
    chk_val("done_one_cycle", 32'(sweep_done_o), 32'd0);
    chk_val("ready_after_done", 32'(sweep_ready_o), 32'd1);
    rd_check("sweep_r10_kept", 5'd10, mk(8'h05, 32'h10), 1'b1);
    rd_check("sweep_r2_cleared", 5'd2, mk(8'h04, 32'h2), 1'b0);
    rd_check("sweep_r31_cleared", 5'd31, mk(8'h04, 32'h31), 1'b0);
  endtask

  task automatic test_back_to_back();
    int bn;
    bit ds;
    sweep_req_i = 1'b1; sweep_epoch_i = 8'h05;
    tick();
    sweep_req_i = 1'b0;
    tick();
    chk_val("cnt_held_during_sweep", 32'(sweep_cnt_o), 32'd3);
    for (int g = 0; g < 100 && !sweep_done_o; g++) tick();
    chk_val("b2b_cnt", 32'(sweep_cnt_o), 32'd1);
    rd_check("b2b_r10_cleared", 5'd10, mk(8'h05, 32'h10), 1'b0);
    tick();
    run_sweep(8'h05, -1, bn, ds);
    chk_val("empty_sweep_cnt", 32'(sweep_cnt_o), 32'd0);
  endtask

  task automatic test_collision();
    int bn;
    bit ds;
    do_reset();
    setup_epochs();
    run_sweep(8'h04, 8, bn, ds);
    chk_val("coll_cnt", 32'(sweep_cnt_o), 32'd2);
    rd_check("coll_r9_kept", 5'd9, mk(8'h04, 32'h99), 1'b1);
    rd_check("swept_r2_rewritten", 5'd2, mk(8'h04, 32'h22), 1'b1);
  endtask

  task automatic test_abort();
    int  bn;
    bit  ds;
    bit  saw_done;
    do_reset();
    setup_epochs();
    sweep_req_i = 1'b1; sweep_epoch_i = 8'h04;
    tick();
    sweep_req_i = 1'b0;
    for (int g = 0; g < 14; g++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_val("abort_busy", 32'(sweep_busy_o), 32'd0);
    chk_val("abort_ready", 32'(sweep_ready_o), 32'd1);
    saw_done = 0;
    for (int g = 0; g < 20; g++) begin
      if (sweep_done_o) saw_done = 1;
      tick();
    end
    chk_val("abort_no_done", 32'(saw_done), 32'd0);
    rd_check("abort_r9_reset", 5'd9, 128'h0, 1'b0);
    wr2(5'd20, mk(8'h07, 32'h20), 1'b1, 5'd21, mk(8'h07, 32'h21), 1'b1);
    run_sweep(8'h07, -1, bn, ds);
    chk_val("post_abort_busy", 32'(bn), 32'd31);
    chk_val("post_abort_cnt", 32'(sweep_cnt_o), 32'd2);
  endtask

  initial begin
    rst_i = 1'b1; we_i = '0; waddr_i = '0; wdata_i = '0; wtag_i = '0;
    raddr_i = '0; sweep_req_i = 1'b0; sweep_epoch_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    test_reset();
    test_write_priority();
    test_bypass();
    test_sweep();
    test_back_to_back();
    test_collision();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
